// File: rtl/rps_round_ctrl.sv
// Round sequencer for the rock-paper-scissors game: takes the player's move, asks the
// predictor for a guess, plays the counter-move, scores it and feeds history back.
module rps_round_ctrl #(
    parameter int WIN_TARGET   = 5,
    parameter int SHOW_CYCLES  = 50000000,
    parameter int PRED_TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [1:0] move,
    output logic       pred_req,
    input  logic       pred_ack,
    input  logic [1:0] pred_choice,
    output logic       hist_valid,
    output logic [3:0] hist_combination,
    output logic       hist_first,
    output logic       move_ready,
    output logic [1:0] ai_move,
    output logic [1:0] result,
    output logic [3:0] player_score,
    output logic [3:0] ai_score,
    output logic       game_over,
    output logic [3:0] timeouts,
    output logic [2:0] state_dbg
);

    localparam int SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam int TW = (PRED_TIMEOUT > 1) ? $clog2(PRED_TIMEOUT) : 1;
    localparam logic [SW-1:0] SHOW_LAST = SW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(PRED_TIMEOUT - 1);
    localparam logic [3:0]    WIN       = 4'(WIN_TARGET);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_RESOLVE = 3'd2,
        S_UPDATE  = 3'd3,
        S_SHOW    = 3'd4,
        S_OVER    = 3'd5
    } state_t;

    state_t          state;
    logic [1:0]      cur_move;
    logic [1:0]      prev_move;
    logic            has_prev;
    logic [1:0]      pred;
    logic [1:0]      rng;
    logic [TW-1:0]   wait_cnt;
    logic [SW-1:0]   show_cnt;

    logic [1:0]      ai_next;
    logic            player_wins;
    logic            is_tie;

    assign state_dbg = state;

    // pred is always stored already folded into 0..2
    always_comb begin
        ai_next     = (pred == 2'd2) ? 2'd0 : pred + 2'd1;
        player_wins = (cur_move == ((ai_next == 2'd2) ? 2'd0 : ai_next + 2'd1));
        is_tie      = (cur_move == ai_next);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= S_IDLE;
            cur_move         <= 2'd0;
            prev_move        <= 2'd0;
            has_prev         <= 1'b0;
            pred             <= 2'd0;
            rng              <= 2'd0;
            wait_cnt         <= '0;
            show_cnt         <= '0;
            pred_req         <= 1'b0;
            hist_valid       <= 1'b0;
            hist_combination <= 4'd0;
            hist_first       <= 1'b0;
            move_ready       <= 1'b1;
            ai_move          <= 2'd0;
            result           <= 2'b00;
            player_score     <= 4'd0;
            ai_score         <= 4'd0;
            game_over        <= 1'b0;
            timeouts         <= 4'd0;
        end else begin
            rng <= (rng == 2'd2) ? 2'd0 : rng + 2'd1;
            if (new_game) begin
                // abort whatever is in flight; the timeout tally survives
                state        <= S_IDLE;
                prev_move    <= 2'd0;
                has_prev     <= 1'b0;
                pred_req     <= 1'b0;
                hist_valid   <= 1'b0;
                move_ready   <= 1'b1;
                ai_move      <= 2'd0;
                result       <= 2'b00;
                player_score <= 4'd0;
                ai_score     <= 4'd0;
                game_over    <= 1'b0;
            end else begin
                hist_valid <= 1'b0;
                case (state)
                    S_IDLE: begin
                        if (move_valid && move != 2'd3) begin
                            cur_move   <= move;
                            move_ready <= 1'b0;
                            pred_req   <= 1'b1;
                            wait_cnt   <= '0;
                            state      <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (pred_ack) begin
                            pred     <= (pred_choice == 2'd3) ? 2'd0 : pred_choice;
                            pred_req <= 1'b0;
                            state    <= S_RESOLVE;
                        end else if (wait_cnt == TO_LAST) begin
                            pred     <= rng;
                            pred_req <= 1'b0;
                            if (timeouts != 4'hf) timeouts <= timeouts + 4'd1;
                            state    <= S_RESOLVE;
                        end else begin
                            wait_cnt <= wait_cnt + TW'(1);
                        end
                    end
                    S_RESOLVE: begin
                        ai_move <= ai_next;
                        if (is_tie) begin
                            result <= 2'b11;
                        end else if (player_wins) begin
                            result       <= 2'b01;
                            player_score <= player_score + 4'd1;
                        end else begin
                            result   <= 2'b10;
                            ai_score <= ai_score + 4'd1;
                        end
                        // history strobe lands in the UPDATE cycle
                        hist_valid       <= 1'b1;
                        hist_combination <= {prev_move, cur_move};
                        hist_first       <= ~has_prev;
                        prev_move        <= cur_move;
                        has_prev         <= 1'b1;
                        state            <= S_UPDATE;
                    end
                    S_UPDATE: begin
                        show_cnt <= '0;
                        state    <= S_SHOW;
                    end
                    S_SHOW: begin
                        if (show_cnt == SHOW_LAST) begin
                            if (player_score == WIN || ai_score == WIN) begin
                                game_over <= 1'b1;
                                state     <= S_OVER;
                            end else begin
                                move_ready <= 1'b1;
                                state      <= S_IDLE;
                            end
                        end else begin
                            show_cnt <= show_cnt + SW'(1);
                        end
                    end
                    S_OVER: begin
                        state <= S_OVER;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rps_round_ctrl.sv
// Bench for rps_round_ctrl: plays scripted rounds and checks scores, history and timing.
module tb_rps_round_ctrl;

    localparam int WT = 2;
    localparam int SC = 3;
    localparam int PT = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       new_game;
    logic       move_valid;
    logic [1:0] move;
    logic       pred_req;
    logic       pred_ack;
    logic [1:0] pred_choice;
    logic       hist_valid;
    logic [3:0] hist_combination;
    logic       hist_first;
    logic       move_ready;
    logic [1:0] ai_move;
    logic [1:0] result;
    logic [3:0] player_score;
    logic [3:0] ai_score;
    logic       game_over;
    logic [3:0] timeouts;
    logic [2:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    // model: {hist_first, hist_combination, ai_move, result, player_score, ai_score}
    logic [16:0] exp_q[$];
    logic [3:0]  m_p;
    logic [3:0]  m_a;
    logic [1:0]  m_prev;
    bit          m_has_prev;

    rps_round_ctrl #(.WIN_TARGET(WT), .SHOW_CYCLES(SC), .PRED_TIMEOUT(PT)) dut (
        .clock(clock), .reset(reset), .new_game(new_game),
        .move_valid(move_valid), .move(move),
        .pred_req(pred_req), .pred_ack(pred_ack), .pred_choice(pred_choice),
        .hist_valid(hist_valid), .hist_combination(hist_combination), .hist_first(hist_first),
        .move_ready(move_ready), .ai_move(ai_move), .result(result),
        .player_score(player_score), .ai_score(ai_score), .game_over(game_over),
        .timeouts(timeouts), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [1:0] f_ai(input logic [1:0] p);
        case (p)
            2'd0: return 2'd1;
            2'd1: return 2'd2;
            2'd2: return 2'd0;
            default: return 2'd1;
        endcase
    endfunction

    // rock beats scissors, paper beats rock, scissors beats paper
    function automatic logic [1:0] f_res(input logic [1:0] m, input logic [1:0] ai);
        if (m == ai) return 2'b11;
        if ((m == 2'd0 && ai == 2'd2) || (m == 2'd1 && ai == 2'd0) || (m == 2'd2 && ai == 2'd1))
            return 2'b01;
        return 2'b10;
    endfunction

    task automatic model_clear();
        m_p = 4'd0; m_a = 4'd0; m_prev = 2'd0; m_has_prev = 1'b0;
    endtask

    // k = ack cycle (0 means never ack); poke pulses move_valid in the first SHOW cycle
    task automatic play_round(input string name, input logic [1:0] m, input logic [1:0] p,
                              input int k, input bit poke);
        int drop_c, hist_c, end_c, r;
        logic [16:0] e, got;
        logic [1:0] ai_e, res_e;
        bit exp_over;
        drop_c = -1; hist_c = -1; end_c = -1;
        r = (k == 0) ? PT : k;
        checks++;
        if (move_ready !== 1'b1) begin
            failures++; $display("FAIL %s_ready: got %b expected 1", name, move_ready);
        end
        if (k == 0) begin
            e = {(m_has_prev ? 1'b0 : 1'b1), m_prev, m, 2'b11, 2'b00, 8'h00};
        end else begin
            ai_e  = f_ai(p);
            res_e = f_res(m, ai_e);
            if (res_e == 2'b01) m_p = m_p + 4'd1;
            else if (res_e == 2'b10) m_a = m_a + 4'd1;
            e = {(m_has_prev ? 1'b0 : 1'b1), m_prev, m, ai_e, res_e, m_p, m_a};
        end
        exp_q.push_back(e);
        m_prev = m; m_has_prev = 1'b1;
        move_valid = 1'b1; move = m;
        for (int c = 1; c <= 40 && end_c < 0; c++) begin
            step();
            move_valid  = 1'b0;
            pred_ack    = (c == k);
            pred_choice = p;
            if (c == 1) begin
                checks++;
                if (pred_req !== 1'b1) begin
                    failures++; $display("FAIL %s_req_rise: got %b expected 1", name, pred_req);
                end
            end
            if (c == r + 1) begin
                checks++;
                if (state_dbg !== 3'd2) begin
                    failures++; $display("FAIL %s_resolve_state: got %0d expected 2", name, state_dbg);
                end
            end
            if (c >= 2 && drop_c < 0 && pred_req === 1'b0) drop_c = c;
            if (hist_valid === 1'b1) begin
                checks++;
                if (hist_c >= 0) begin
                    failures++; $display("FAIL %s_hist_len: hist_valid again at cycle %0d", name, c);
                end else if (exp_q.size() == 0) begin
                    hist_c = c;
                    failures++; $display("FAIL %s_sb_empty: hist_valid with no expectation", name);
                end else begin
                    hist_c = c;
                    got = {hist_first, hist_combination, ai_move, result, player_score, ai_score};
                    e = exp_q.pop_front();
                    if (e[11:10] == 2'b11) begin
                        if (ai_move > 2'd2) begin
                            failures++; $display("FAIL %s_to_ai: got %0d expected 0..2", name, ai_move);
                        end
                        res_e = f_res(m, ai_move);
                        if (res_e == 2'b01) m_p = m_p + 4'd1;
                        else if (res_e == 2'b10) m_a = m_a + 4'd1;
                        e[11:0] = {ai_move, res_e, m_p, m_a};
                    end
                    checks++;
                    if (got !== e) begin
                        failures++; $display("FAIL %s_outcome: got %h expected %h", name, got, e);
                    end
                end
            end
            if (poke && hist_c > 0 && c == hist_c + 1) begin
                move_valid = 1'b1; move = 2'd0;
            end
            if (move_ready === 1'b1 || game_over === 1'b1) end_c = c;
        end
        pred_ack = 1'b0;
        move_valid = 1'b0;
        exp_over = (m_p == 4'(WT)) || (m_a == 4'(WT));
        checks++;
        if (drop_c !== r + 1) begin
            failures++; $display("FAIL %s_req_drop: got cycle %0d expected %0d", name, drop_c, r + 1);
        end
        checks++;
        if (hist_c !== r + 2) begin
            failures++; $display("FAIL %s_hist_cycle: got cycle %0d expected %0d", name, hist_c, r + 2);
        end
        checks++;
        if (end_c !== r + 3 + SC) begin
            failures++; $display("FAIL %s_show_len: got cycle %0d expected %0d", name, end_c, r + 3 + SC);
        end
        checks++;
        if (game_over !== exp_over) begin
            failures++; $display("FAIL %s_game_over: got %b expected %b", name, game_over, exp_over);
        end
        exp_q.delete();
    endtask

    task automatic pulse_new_game(input string name);
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        model_clear();
        checks++;
        if ({move_ready, player_score, ai_score, result, ai_move, game_over, pred_req, state_dbg}
            !== {1'b1, 4'd0, 4'd0, 2'b00, 2'd0, 1'b0, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL %s_clear: got rdy=%b ps=%0d as=%0d res=%b ai=%0d go=%b req=%b st=%0d expected 1 0 0 00 0 0 0 0",
                     name, move_ready, player_score, ai_score, result, ai_move, game_over, pred_req, state_dbg);
        end
    endtask

    task automatic test_reset();
        logic [27:0] got;
        reset = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            got = {move_ready, pred_req, hist_valid, hist_first, hist_combination, ai_move, result,
                   player_score, ai_score, game_over, timeouts, state_dbg};
            checks++;
            if (got !== {1'b1, 27'd0}) begin
                failures++; $display("FAIL reset_values_%0d: got %h expected %h", i, got, {1'b1, 27'd0});
            end
            reset = 1'b0;
            step();
        end
        model_clear();
    endtask

    task automatic test_rounds();
        play_round("ai_win", 2'd0, 2'd0, 1, 1'b0);
        play_round("player_win", 2'd2, 2'd0, 1, 1'b0);
        play_round("tie", 2'd1, 2'd0, 2, 1'b0);
    endtask

    task automatic test_timeout();
        pulse_new_game("ng_pre_timeout");
        play_round("timeout", 2'd1, 2'd0, 0, 1'b0);
        checks++;
        if (timeouts !== 4'd1) begin
            failures++; $display("FAIL timeout_count: got %0d expected 1", timeouts);
        end
        pulse_new_game("ng_keep_timeouts");
        checks++;
        if (timeouts !== 4'd1) begin
            failures++; $display("FAIL timeout_kept: got %0d expected 1", timeouts);
        end
        play_round("late_ack", 2'd0, 2'd1, PT, 1'b0);
        checks++;
        if (timeouts !== 4'd1) begin
            failures++; $display("FAIL late_ack_timeouts: got %0d expected 1", timeouts);
        end
    endtask

    task automatic test_ignored();
        pulse_new_game("ng_pre_ignore");
        move_valid = 1'b1; move = 2'd3;
        step();
        move_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({pred_req, move_ready, state_dbg} !== {1'b0, 1'b1, 3'd0}) begin
                failures++; $display("FAIL illegal_move_%0d: got req=%b rdy=%b st=%0d expected 0 1 0",
                                     i, pred_req, move_ready, state_dbg);
            end
            step();
        end
        play_round("show_poke", 2'd1, 2'd1, 2, 1'b1);
        step();
        checks++;
        if ({pred_req, move_ready, state_dbg} !== {1'b0, 1'b1, 3'd0}) begin
            failures++; $display("FAIL poke_dropped: got req=%b rdy=%b st=%0d expected 0 1 0",
                                 pred_req, move_ready, state_dbg);
        end
    endtask

    task automatic test_match_end();
        pulse_new_game("ng_pre_match");
        play_round("match_1", 2'd0, 2'd0, 1, 1'b0);
        play_round("match_2", 2'd0, 2'd3, 2, 1'b0);
        move_valid = 1'b1; move = 2'd0;
        step();
        move_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({game_over, move_ready, pred_req, ai_score} !== {1'b1, 1'b0, 1'b0, 4'd2}) begin
                failures++; $display("FAIL over_hold_%0d: got go=%b rdy=%b req=%b as=%0d expected 1 0 0 2",
                                     i, game_over, move_ready, pred_req, ai_score);
            end
            step();
        end
        pulse_new_game("ng_after_over");
    endtask

    task automatic test_reset_in_req();
        logic [27:0] got;
        move_valid = 1'b1; move = 2'd2;
        step();
        move_valid = 1'b0;
        step();
        checks++;
        if (pred_req !== 1'b1) begin
            failures++; $display("FAIL rst_req_entry: got %b expected 1", pred_req);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_clear();
        got = {move_ready, pred_req, hist_valid, hist_first, hist_combination, ai_move, result,
               player_score, ai_score, game_over, timeouts, state_dbg};
        checks++;
        if (got !== {1'b1, 27'd0}) begin
            failures++; $display("FAIL rst_in_req_values: got %h expected %h", got, {1'b1, 27'd0});
        end
        play_round("after_reset", 2'd1, 2'd2, 3, 1'b0);
    endtask

    initial begin
        reset = 1'b1; new_game = 1'b0; move_valid = 1'b0; move = 2'd0;
        pred_ack = 1'b0; pred_choice = 2'd0;
        model_clear();
        test_reset();
        test_rounds();
        test_timeout();
        test_ignored();
        test_match_end();
        test_reset_in_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end

endmodule
